// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mult_pkg
// Brief    : Shared width, operation encoding and strobe priority decode for
//            the signed shift-add multiplier datapath.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLR   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_SHIFT = 3'd5
  } mult_op_t;

  // Strobes that lose priority are simply dropped for the cycle.
  function automatic mult_op_t decode_op(
    input logic load,
    input logic clr,
    input logic add,
    input logic sub,
    input logic shift
  );
    mult_op_t op;
    if (load)       op = OP_LOAD;
    else if (clr)   op = OP_CLR;
    else if (add)   op = OP_ADD;
    else if (sub)   op = OP_SUB;
    else if (shift) op = OP_SHIFT;
    else            op = OP_NONE;
    return op;
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/add_sub_unit.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_unit
// Brief    : Ripple-carry adder/subtractor; sub inverts b and injects carry-in.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_unit #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] w_b_x;
  logic [WIDTH-1:0] w_carry;

  assign w_b_x      = b ^ {WIDTH{sub}};
  assign w_carry[0] = sub;

  // Carry out of the top bit is intentionally never formed.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i] = a[i] ^ w_b_x[i] ^ w_carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign w_carry[i+1] = (a[i] & w_b_x[i]) | (w_carry[i] & (a[i] ^ w_b_x[i]));
    end
  end

endmodule : add_sub_unit
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mult_datapath
// Brief    : X/A/B register datapath for the signed shift-add multiplier;
//            {Aval,Bval} holds the signed product once Done rises.
// Revision : 1.0 - initial release
// ============================================================================
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Clear_A,
  input  logic             Add_En,
  input  logic             Sub_En,
  input  logic             Shift_En,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             M,
  output logic             Done
);

  localparam int                C_CNT_W   = $clog2(WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(WIDTH);

  mult_op_t            op;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                x_q, x_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic                done_q, done_d;

  always_comb begin
    op = decode_op(ClearA_LoadB, Clear_A, Add_En, Sub_En, Shift_En);
  end

  // A and the multiplicand are sign-extended by one bit so X catches the sign.
  add_sub_unit #(
    .WIDTH (WIDTH + 1)
  ) u_add_sub (
    .a   ({a_q[WIDTH-1], a_q}),
    .b   ({Din[WIDTH-1], Din}),
    .sub (op == OP_SUB),
    .sum (sum)
  );

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    x_d    = x_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    case (op)
      OP_LOAD: begin
        b_d    = Din;
        a_d    = '0;
        x_d    = 1'b0;
        cnt_d  = '0;
        done_d = 1'b0;
      end
      OP_CLR: begin
        a_d    = '0;
        x_d    = 1'b0;
        cnt_d  = '0;
        done_d = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        {x_d, a_d} = sum;
      end
      OP_SHIFT: begin
        a_d = {x_q, a_q[WIDTH-1:1]};
        b_d = {a_q[0], b_q[WIDTH-1:1]};
        if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (cnt_d == C_CNT_MAX) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      x_q    <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      x_q    <= x_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign M    = b_q[0];
  assign Done = done_q;

endmodule : mult_datapath
`default_nettype wire

// File: tb/tb_mult_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_datapath
// Brief    : Scoreboard bench for mult_datapath; the stimulus plays the control
//            FSM and a monitor checks each product when Done rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_datapath;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic       Clear_A = 1'b0;
  logic       Add_En = 1'b0;
  logic       Sub_En = 1'b0;
  logic       Shift_En = 1'b0;
  logic [7:0] Din = 8'h00;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       M;
  logic       Done;

  typedef struct {
    logic [15:0] prod;
    logic        x;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_prev = 1'b0;

  mult_datapath #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ClearA_LoadB (ClearA_LoadB),
    .Clear_A      (Clear_A),
    .Add_En       (Add_En),
    .Sub_En       (Sub_En),
    .Shift_En     (Shift_En),
    .Din          (Din),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .M            (M),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock of stimulus; strobes drop afterwards, Din stays held.
  task automatic drive(input logic rst, input logic ld, input logic clr,
                       input logic add, input logic sub, input logic sh,
                       input logic [7:0] din);
    Reset = rst; ClearA_LoadB = ld; Clear_A = clr;
    Add_En = add; Sub_En = sub; Shift_En = sh; Din = din;
    @(posedge Clk);
    #1;
    Reset = 1'b0; ClearA_LoadB = 1'b0; Clear_A = 1'b0;
    Add_En = 1'b0; Sub_En = 1'b0; Shift_En = 1'b0;
  endtask

  task automatic maybe_idle(input logic [7:0] din);
    if ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0, 0, 0, din);
  endtask

  // Full Booth-free signed run: add on each set multiplier bit, subtract on the sign bit.
  task automatic run_mult(input logic [7:0] b, input logic [7:0] s);
    exp_t e;
    logic signed [15:0] p;
    p = $signed(b) * $signed(s);
    e.prod = p;
    e.x    = p[15];
    exp_q.push_back(e);
    drive(0, 1, 0, 0, 0, 0, b);
    maybe_idle(s);
    drive(0, 0, 1, 0, 0, 0, s);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        drive(0, 0, 0, i != 7, i == 7, 0, s);
        if (i == 7 && b == 8'h80 && s == 8'h80) begin
          check("neg128_sub_x", {31'd0, X}, 32'd0);
          check("neg128_sub_a", {24'd0, Aval}, 32'h80);
        end
      end
      maybe_idle(s);
      drive(0, 0, 0, 0, 0, 1, s);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 with no run outstanding, expected 0");
      end else begin
        e = exp_q.pop_front();
        check("product", {16'd0, Aval, Bval}, {16'd0, e.prod});
        check("product_x", {31'd0, X}, {31'd0, e.x});
      end
    end
    done_prev = Done;
  end

  initial begin
    int waited;
    drive(1, 0, 0, 0, 0, 0, 8'h00);

    // Reset after arbitrary ops
    drive(0, 1, 0, 0, 0, 0, 8'h5A);
    drive(0, 0, 0, 1, 0, 0, 8'hC3);
    drive(0, 0, 0, 0, 0, 1, 8'hC3);
    drive(1, 0, 0, 0, 0, 0, 8'hC3);
    check("rst_a", {24'd0, Aval}, 32'h0);
    check("rst_b", {24'd0, Bval}, 32'h0);
    check("rst_x", {31'd0, X}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_m", {31'd0, M}, 32'd0);

    run_mult(8'h03, 8'h07);
    run_mult(8'h05, 8'hFD);
    run_mult(8'h80, 8'h80);

    // Done is sticky across extra shifts and clears on Clear_A
    drive(0, 0, 0, 0, 0, 1, 8'h80);
    drive(0, 0, 0, 0, 0, 1, 8'h80);
    check("done_sticky", {31'd0, Done}, 32'd1);
    drive(0, 0, 1, 0, 0, 0, 8'h80);
    check("clr_done", {31'd0, Done}, 32'd0);
    check("clr_a", {24'd0, Aval}, 32'h0);

    // Sub sign handling and Add priority over Shift
    drive(0, 1, 0, 0, 0, 0, 8'hA5);
    drive(0, 0, 0, 1, 0, 0, 8'h7F);
    check("add_7f_a", {24'd0, Aval}, 32'h7F);
    drive(0, 0, 0, 0, 1, 0, 8'h80);
    check("sub_x", {31'd0, X}, 32'd0);
    check("sub_a", {24'd0, Aval}, 32'hFF);
    drive(0, 0, 0, 1, 0, 1, 8'h01);
    check("prio_a", {24'd0, Aval}, 32'h00);
    check("prio_x", {31'd0, X}, 32'd0);
    check("prio_b", {24'd0, Bval}, 32'hA5);
    drive(0, 0, 0, 0, 0, 0, 8'h01);
    check("hold_b", {24'd0, Bval}, 32'hA5);
    check("hold_m", {31'd0, M}, 32'd1);

    // Reset mid-run, then a clean run
    drive(0, 1, 0, 0, 0, 0, 8'h6B);
    drive(0, 0, 1, 0, 0, 0, 8'h9C);
    drive(0, 0, 0, 1, 0, 0, 8'h9C);
    drive(0, 0, 0, 0, 0, 1, 8'h9C);
    drive(0, 0, 0, 0, 0, 1, 8'h9C);
    drive(0, 0, 0, 0, 0, 1, 8'h9C);
    drive(1, 0, 0, 0, 0, 1, 8'h9C);
    check("midrst_a", {24'd0, Aval}, 32'h0);
    check("midrst_b", {24'd0, Bval}, 32'h0);
    check("midrst_x", {31'd0, X}, 32'd0);
    check("midrst_done", {31'd0, Done}, 32'd0);
    check("midrst_m", {31'd0, M}, 32'd0);
    run_mult(8'h6B, 8'h9C);

    for (int k = 0; k < 24; k++) begin
      run_mult(8'($urandom), 8'($urandom));
    end
    run_mult(8'h7F, 8'h80);
    run_mult(8'h00, 8'hFF);
    run_mult(8'hFF, 8'hFF);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge Clk);
      waited++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mult_datapath
`default_nettype wire
